// File: rtl/io_reg_wr_file.sv
// io_reg_wr_file
//   Write side of the core-resident I/O register file. It holds SPL, SPH,
//   SREG, RAMPZ and EIND. OUT-type writes from the core data bus are merged
//   with the core's own updates to these registers: stack pointer steps,
//   ALU flag writes, and I-flag changes on interrupt acknowledge and RETI.
//   All outputs come straight from registers.
//
// Ports
//   cp2           in   core clock, rising edge
//   ireset        in   asynchronous reset, active low
//   adr[5:0]      in   I/O address
//   iowe          in   I/O write strobe (one cycle per write)
//   dbusout[7:0]  in   write data from the core
//   sp_incr       in   SP <= SP + 1 (pop / ret step)
//   sp_decr       in   SP <= SP - 1 (push / call step)
//   sreg_fl_in    in   new values for SREG[6:0]
//   sreg_fl_wr_en in   per-bit update enables for SREG[6:0]
//   irq_ack       in   interrupt accepted, clears I
//   reti          in   RETI executed, sets I
//   spl_out, sph_out, sreg_out, rampz_out, eind_out   out   register values
module io_reg_wr_file #(
    parameter bit          pc22b      = 1'b0,
    parameter logic [15:0] sp_rst_val = 16'h0000,
    parameter logic [7:0]  rampz_msk  = 8'hFF
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] adr,
    input  logic       iowe,
    input  logic [7:0] dbusout,
    input  logic       sp_incr,
    input  logic       sp_decr,
    input  logic [6:0] sreg_fl_in,
    input  logic [6:0] sreg_fl_wr_en,
    input  logic       irq_ack,
    input  logic       reti,
    output logic [7:0] spl_out,
    output logic [7:0] sph_out,
    output logic [7:0] sreg_out,
    output logic [7:0] rampz_out,
    output logic [7:0] eind_out
);

    localparam logic [5:0] adr_rampz = 6'h3B;
    localparam logic [5:0] adr_eind  = 6'h3C;
    localparam logic [5:0] adr_spl   = 6'h3D;
    localparam logic [5:0] adr_sph   = 6'h3E;
    localparam logic [5:0] adr_sreg  = 6'h3F;

    logic        wr_spl;
    logic        wr_sph;
    logic        wr_sreg;
    logic        wr_rampz;
    logic [15:0] sp_nxt;
    logic [7:0]  sreg_nxt;

    assign wr_spl   = iowe && (adr == adr_spl);
    assign wr_sph   = iowe && (adr == adr_sph);
    assign wr_sreg  = iowe && (adr == adr_sreg);
    assign wr_rampz = iowe && (adr == adr_rampz);

    // One stack step. Simultaneous increment and decrement cancel out.
    function automatic logic [15:0] sp_step(input logic [15:0] sp,
                                            input logic inc,
                                            input logic dec);
        case ({inc, dec})
            2'b10:   return sp + 16'd1;
            2'b01:   return sp - 16'd1;
            default: return sp;
        endcase
    endfunction

    // A byte write to SPL or SPH takes precedence over any stack step in the
    // same cycle; the step is dropped rather than applied to the other byte.
    always_comb begin
        sp_nxt = sp_step({sph_out, spl_out}, sp_incr, sp_decr);
        if (wr_spl)
            sp_nxt = {sph_out, dbusout};
        else if (wr_sph)
            sp_nxt = {dbusout, spl_out};
    end

    // Flag bits merge per-bit; the I bit gives irq_ack priority over reti.
    // A direct SREG write replaces everything.
    always_comb begin
        sreg_nxt[6:0] = (sreg_fl_in & sreg_fl_wr_en) | (sreg_out[6:0] & ~sreg_fl_wr_en);
        sreg_nxt[7]   = irq_ack ? 1'b0 : (reti ? 1'b1 : sreg_out[7]);
        if (wr_sreg)
            sreg_nxt = dbusout;
    end

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            spl_out   <= sp_rst_val[7:0];
            sph_out   <= sp_rst_val[15:8];
            sreg_out  <= 8'h00;
            rampz_out <= 8'h00;
        end else begin
            spl_out  <= sp_nxt[7:0];
            sph_out  <= sp_nxt[15:8];
            sreg_out <= sreg_nxt;
            if (wr_rampz)
                rampz_out <= dbusout & rampz_msk;
        end
    end

    generate
        if (pc22b) begin : g_eind
            logic wr_eind;
            assign wr_eind = iowe && (adr == adr_eind);

            always_ff @(posedge cp2 or negedge ireset) begin
                if (!ireset)
                    eind_out <= 8'h00;
                else if (wr_eind)
                    eind_out <= dbusout;
            end
        end else begin : g_no_eind
            assign eind_out = 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_io_reg_wr_file.sv
// Bench for io_reg_wr_file. Two instances share the stimulus: dut_a has EIND
// built and a one-bit RAMPZ, dut_b has no EIND and a non-zero SP reset value.
module tb_io_reg_wr_file;

    localparam bit          A_PC22B = 1'b1;
    localparam logic [15:0] A_SPRST = 16'h0000;
    localparam logic [7:0]  A_MSK   = 8'h01;
    localparam bit          B_PC22B = 1'b0;
    localparam logic [15:0] B_SPRST = 16'hA5C3;
    localparam logic [7:0]  B_MSK   = 8'hFF;

    logic       cp2;
    logic       ireset;
    logic [5:0] adr;
    logic       iowe;
    logic [7:0] dbusout;
    logic       sp_incr;
    logic       sp_decr;
    logic [6:0] sreg_fl_in;
    logic [6:0] sreg_fl_wr_en;
    logic       irq_ack;
    logic       reti;

    logic [7:0] a_spl, a_sph, a_sreg, a_rampz, a_eind;
    logic [7:0] b_spl, b_sph, b_sreg, b_rampz, b_eind;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference state, one entry per instance.
    logic [15:0] m_sp    [2];
    logic [7:0]  m_sreg  [2];
    logic [7:0]  m_rampz [2];
    logic [7:0]  m_eind  [2];

    io_reg_wr_file #(.pc22b(A_PC22B), .sp_rst_val(A_SPRST), .rampz_msk(A_MSK)) dut_a (
        .cp2(cp2), .ireset(ireset), .adr(adr), .iowe(iowe), .dbusout(dbusout),
        .sp_incr(sp_incr), .sp_decr(sp_decr), .sreg_fl_in(sreg_fl_in),
        .sreg_fl_wr_en(sreg_fl_wr_en), .irq_ack(irq_ack), .reti(reti),
        .spl_out(a_spl), .sph_out(a_sph), .sreg_out(a_sreg),
        .rampz_out(a_rampz), .eind_out(a_eind)
    );

    io_reg_wr_file #(.pc22b(B_PC22B), .sp_rst_val(B_SPRST), .rampz_msk(B_MSK)) dut_b (
        .cp2(cp2), .ireset(ireset), .adr(adr), .iowe(iowe), .dbusout(dbusout),
        .sp_incr(sp_incr), .sp_decr(sp_decr), .sreg_fl_in(sreg_fl_in),
        .sreg_fl_wr_en(sreg_fl_wr_en), .irq_ack(irq_ack), .reti(reti),
        .spl_out(b_spl), .sph_out(b_sph), .sreg_out(b_sreg),
        .rampz_out(b_rampz), .eind_out(b_eind)
    );

    initial begin
        cp2 = 1'b0;
        forever #5 cp2 = ~cp2;
    end

    always @(posedge cp2) begin
        if (ireset && iowe)
            assert (!$isunknown(adr)) else $error("iowe with unknown adr");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack pointer as plain integer arithmetic modulo 65536.
    function automatic logic [15:0] model_sp(input logic [15:0] sp);
        int v;
        v = int'(sp);
        if (iowe && adr == 6'h3D) return {sp[15:8], dbusout};
        if (iowe && adr == 6'h3E) return {dbusout, sp[7:0]};
        if (sp_incr && !sp_decr) v = (v + 1) % 65536;
        if (sp_decr && !sp_incr) v = (v + 65535) % 65536;
        return v[15:0];
    endfunction

    function automatic logic [7:0] model_sreg(input logic [7:0] s);
        logic [7:0] r;
        if (iowe && adr == 6'h3F) return dbusout;
        r = s;
        for (int n = 0; n < 7; n++)
            if (sreg_fl_wr_en[n]) r[n] = sreg_fl_in[n];
        if (irq_ack)   r[7] = 1'b0;
        else if (reti) r[7] = 1'b1;
        return r;
    endfunction

    always @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            m_sp[0] <= A_SPRST;
            m_sp[1] <= B_SPRST;
            for (int i = 0; i < 2; i++) begin
                m_sreg[i]  <= 8'h00;
                m_rampz[i] <= 8'h00;
                m_eind[i]  <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_sp[i]   <= model_sp(m_sp[i]);
                m_sreg[i] <= model_sreg(m_sreg[i]);
                if (iowe && adr == 6'h3B)
                    m_rampz[i] <= dbusout & ((i == 0) ? A_MSK : B_MSK);
                if (iowe && adr == 6'h3C && ((i == 0) ? A_PC22B : B_PC22B))
                    m_eind[i] <= dbusout;
            end
        end
    end

    always @(negedge cp2) begin
        if (chk_en) begin
            chk("a_sp",    {a_sph, a_spl}, m_sp[0]);
            chk("a_sreg",  {8'h00, a_sreg},  {8'h00, m_sreg[0]});
            chk("a_rampz", {8'h00, a_rampz}, {8'h00, m_rampz[0]});
            chk("a_eind",  {8'h00, a_eind},  {8'h00, m_eind[0]});
            chk("b_sp",    {b_sph, b_spl}, m_sp[1]);
            chk("b_sreg",  {8'h00, b_sreg},  {8'h00, m_sreg[1]});
            chk("b_rampz", {8'h00, b_rampz}, {8'h00, m_rampz[1]});
            chk("b_eind",  {8'h00, b_eind},  {8'h00, m_eind[1]});
        end
    end

    task automatic drive(input logic we, input logic [5:0] a, input logic [7:0] d,
                         input logic inc, input logic dec,
                         input logic [6:0] fi, input logic [6:0] fe,
                         input logic ack, input logic rt);
        iowe = we; adr = a; dbusout = d; sp_incr = inc; sp_decr = dec;
        sreg_fl_in = fi; sreg_fl_wr_en = fe; irq_ack = ack; reti = rt;
        @(negedge cp2);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        drive(1'b1, a, d, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0);
    endtask

    initial begin
        ireset = 1'b1;
        iowe = 1'b0; adr = 6'h00; dbusout = 8'h00; sp_incr = 1'b0; sp_decr = 1'b0;
        sreg_fl_in = 7'h00; sreg_fl_wr_en = 7'h00; irq_ack = 1'b0; reti = 1'b0;
        #3 ireset = 1'b0;
        @(negedge cp2);
        chk_en = 1'b1;
        @(negedge cp2);
        chk("rst_a_sp",   {a_sph, a_spl}, 16'h0000);
        chk("rst_b_sp",   {b_sph, b_spl}, 16'hA5C3);
        chk("rst_a_sreg", {8'h00, a_sreg}, 16'h0000);
        ireset = 1'b1;

        // SPL/SPH writes then an increment carrying into SPH
        wr(6'h3D, 8'hFF);
        wr(6'h3E, 8'h10);
        drive(1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0);
        chk("sp_incr_carry", {a_sph, a_spl}, 16'h1100);

        // Wrap below zero, then simultaneous incr/decr
        wr(6'h3D, 8'h00);
        wr(6'h3E, 8'h00);
        drive(1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 7'h00, 7'h00, 1'b0, 1'b0);
        chk("sp_decr_wrap", {a_sph, a_spl}, 16'hFFFF);
        drive(1'b0, 6'h00, 8'h00, 1'b1, 1'b1, 7'h00, 7'h00, 1'b0, 1'b0);
        chk("sp_incr_decr", {a_sph, a_spl}, 16'hFFFF);

        // Byte write beats a concurrent decrement
        wr(6'h3D, 8'h34);
        wr(6'h3E, 8'h12);
        drive(1'b1, 6'h3D, 8'hAA, 1'b0, 1'b1, 7'h00, 7'h00, 1'b0, 1'b0);
        chk("sp_wr_beats_decr", {a_sph, a_spl}, 16'h12AA);

        // SREG flag merge with irq_ack winning over reti, then direct write
        wr(6'h3F, 8'h80);
        drive(1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 7'h02, 7'h03, 1'b1, 1'b1);
        chk("sreg_merge", {8'h00, a_sreg}, 16'h0002);
        drive(1'b1, 6'h3F, 8'h55, 1'b0, 1'b0, 7'h02, 7'h03, 1'b1, 1'b1);
        chk("sreg_iowe", {8'h00, a_sreg}, 16'h0055);

        // RAMPZ mask and EIND presence
        wr(6'h3B, 8'hFF);
        chk("rampz_a", {8'h00, a_rampz}, 16'h0001);
        chk("rampz_b", {8'h00, b_rampz}, 16'h00FF);
        wr(6'h3C, 8'h7E);
        chk("eind_a", {8'h00, a_eind}, 16'h007E);
        chk("eind_b", {8'h00, b_eind}, 16'h0000);
        drive(1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 7'h00, 7'h00, 1'b0, 1'b0);

        // Reset asserted between clock edges takes effect at once
        #2 ireset = 1'b0;
        #1;
        chk("amid_sp",    {a_sph, a_spl}, 16'h0000);
        chk("amid_sreg",  {8'h00, a_sreg},  16'h0000);
        chk("amid_rampz", {8'h00, a_rampz}, 16'h0000);
        chk("amid_eind",  {8'h00, a_eind},  16'h0000);
        chk("bmid_sp",    {b_sph, b_spl}, 16'hA5C3);
        @(negedge cp2);
        ireset = 1'b1;

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [5:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(6'h3B + $urandom_range(0, 4));
            iowe = ($urandom_range(0, 9) < 3); adr = ra; dbusout = 8'($urandom);
            sp_incr = ($urandom_range(0, 3) == 0); sp_decr = ($urandom_range(0, 3) == 0);
            sreg_fl_in = 7'($urandom); sreg_fl_wr_en = 7'($urandom);
            irq_ack = ($urandom_range(0, 9) == 0); reti = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 ireset = 1'b0;
                #4 ireset = 1'b1;
            end
            @(negedge cp2);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
